// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - round-robin arbiter of ICache/DCache misses onto one memory port
// Registered memory request with a per-transaction wait-counter timeout.
module cache_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_ack,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_err,

    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_ack,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_err,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    // The count seen in the last permitted BUSY cycle; a missing mem_ack there times out.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic       last_d;
    logic [7:0] wait_cnt;
    logic       grant_i;

    // ICache wins if alone, or on a tie when DCache was served last.
    assign grant_i = ic_req && (!dc_req || last_d);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last_d    <= 1'b1;
            wait_cnt  <= 8'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ic_ack    <= 1'b0;
            ic_err    <= 1'b0;
            ic_rdata  <= '0;
            dc_ack    <= 1'b0;
            dc_err    <= 1'b0;
            dc_rdata  <= '0;
        end else begin
            ic_ack <= 1'b0;
            ic_err <= 1'b0;
            dc_ack <= 1'b0;
            dc_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        state     <= BUSY_I;
                        last_d    <= 1'b0;
                        wait_cnt  <= 8'd0;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= ic_addr;
                        mem_wdata <= '0;
                    end else if (dc_req) begin
                        state     <= BUSY_D;
                        last_d    <= 1'b1;
                        wait_cnt  <= 8'd0;
                        mem_req   <= 1'b1;
                        mem_we    <= dc_we;
                        mem_addr  <= dc_addr;
                        mem_wdata <= dc_wdata;
                    end
                end
                BUSY_I, BUSY_D: begin
                    // mem_ack takes priority over a timeout landing in the same cycle.
                    if (mem_ack || wait_cnt == WAIT_LAST) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        if (state == BUSY_I) begin
                            ic_ack   <= 1'b1;
                            ic_err   <= !mem_ack;
                            ic_rdata <= mem_ack ? mem_rdata : '0;
                        end else begin
                            dc_ack   <= 1'b1;
                            dc_err   <= !mem_ack;
                            dc_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          ic_req, ic_ack, ic_err;
    logic [AW-1:0] ic_addr;
    logic [DW-1:0] ic_rdata;
    logic          dc_req, dc_we, dc_ack, dc_err;
    logic [AW-1:0] dc_addr;
    logic [DW-1:0] dc_wdata, dc_rdata;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_rdata(ic_rdata), .ic_err(ic_err),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_ack(dc_ack), .dc_rdata(dc_rdata), .dc_err(dc_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in IDLE with the request(s) already driven; ends one cycle after RESP.
    // delay = number of mem_req cycles before mem_ack (large value = never ack).
    task automatic run_txn(input string tag, input bit exp_d, input bit exp_we,
                           input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                           input int delay, input logic [31:0] rd,
                           input logic [31:0] exp_rdata, input bit exp_err, input int exp_busy);
        int wait_cyc = 0;
        int busy = 0;
        bit held = 1'b1;
        while (!mem_req && wait_cyc < 4) begin
            tick();
            wait_cyc++;
        end
        check({tag, "_grant_lat"}, wait_cyc, 1);
        while (mem_req && busy < 300) begin
            busy++;
            if (mem_we !== exp_we || mem_addr !== exp_addr || ic_ack || dc_ack) held = 1'b0;
            if (exp_d && mem_wdata !== exp_wdata) held = 1'b0;
            if (busy - 1 == delay) begin
                mem_ack   = 1'b1;
                mem_rdata = rd;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'h5A5A_5A5A;
            end
            tick();
        end
        mem_ack = 1'b0;
        check({tag, "_busy_cycles"}, busy, exp_busy);
        check({tag, "_mem_held"}, held, 1);
        check({tag, "_acks"}, {ic_ack, dc_ack}, exp_d ? 2'b01 : 2'b10);
        check({tag, "_err"}, exp_d ? dc_err : ic_err, exp_err);
        check({tag, "_other_err"}, exp_d ? ic_err : dc_err, 0);
        check({tag, "_rdata"}, exp_d ? dc_rdata : ic_rdata, exp_rdata);
        if (exp_d) dc_req = 1'b0;
        else       ic_req = 1'b0;
        tick();
        check({tag, "_post_ack_err"}, {ic_ack, dc_ack, ic_err, dc_err}, 0);
        check({tag, "_rdata_hold"}, exp_d ? dc_rdata : ic_rdata, exp_rdata);
    endtask

    task automatic set_dc(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        dc_req   = 1'b1;
        dc_we    = we;
        dc_addr  = addr;
        dc_wdata = wdata;
    endtask

    task automatic set_ic(input logic [31:0] addr);
        ic_req  = 1'b1;
        ic_addr = addr;
    endtask

    initial begin
        reset = 1'b1;
        ic_req = 1'b0; ic_addr = '0;
        dc_req = 1'b0; dc_we = 1'b0; dc_addr = '0; dc_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        tick();
        tick();
        check("rst_mem", {mem_req, mem_we, mem_addr, mem_wdata}, 0);
        check("rst_acks", {ic_ack, dc_ack, ic_err, dc_err}, 0);
        check("rst_ic_rdata", ic_rdata, 0);
        check("rst_dc_rdata", dc_rdata, 0);
        reset = 1'b0;

        set_ic(32'h0000_0100);
        run_txn("ic_fill", 0, 0, 32'h0000_0100, 0, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 4);

        set_dc(0, 32'h0000_0040, 32'h1111_1111);
        run_txn("dc_zero_wait", 1, 0, 32'h0000_0040, 32'h1111_1111, 0, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 1);

        set_ic(32'h0000_0200);
        set_dc(0, 32'h0000_0300, 32'h2222_2222);
        run_txn("tie1_i", 0, 0, 32'h0000_0200, 0, 1, 32'hA1A1_A1A1, 32'hA1A1_A1A1, 0, 2);
        run_txn("tie1_d", 1, 0, 32'h0000_0300, 32'h2222_2222, 2, 32'hB2B2_B2B2, 32'hB2B2_B2B2, 0, 3);

        set_ic(32'h0000_0204);
        set_dc(0, 32'h0000_0304, 32'h3333_3333);
        run_txn("tie2_i", 0, 0, 32'h0000_0204, 0, 0, 32'hC3C3_C3C3, 32'hC3C3_C3C3, 0, 1);
        run_txn("tie2_d", 1, 0, 32'h0000_0304, 32'h3333_3333, 1, 32'hD4D4_D4D4, 32'hD4D4_D4D4, 0, 2);

        set_ic(32'h0000_0208);
        run_txn("ic_alone", 0, 0, 32'h0000_0208, 0, 0, 32'hE5E5_E5E5, 32'hE5E5_E5E5, 0, 1);
        set_ic(32'h0000_020C);
        set_dc(0, 32'h0000_0308, 32'h4444_4444);
        run_txn("tie3_d", 1, 0, 32'h0000_0308, 32'h4444_4444, 0, 32'hF6F6_F6F6, 32'hF6F6_F6F6, 0, 1);
        run_txn("tie3_i", 0, 0, 32'h0000_020C, 0, 1, 32'h0707_0707, 32'h0707_0707, 0, 2);

        mem_ack   = 1'b1;
        mem_rdata = 32'h7777_7777;
        tick();
        mem_ack = 1'b0;
        tick();
        check("idle_ack_ignored", {mem_req, ic_ack, dc_ack}, 0);
        check("idle_ic_rdata_hold", ic_rdata, 32'h0707_0707);

        set_dc(1, 32'h0000_2004, 32'h1234_5678);
        run_txn("dc_wb", 1, 1, 32'h0000_2004, 32'h1234_5678, 2, 32'hFFFF_FFFF, 0, 0, 3);

        set_ic(32'h0000_0400);
        run_txn("ic_timeout", 0, 0, 32'h0000_0400, 0, 1000, 0, 0, 1, 4);
        set_dc(0, 32'h0000_0404, 32'h5555_5555);
        run_txn("dc_timeout", 1, 0, 32'h0000_0404, 32'h5555_5555, 1000, 0, 0, 1, 4);

        set_dc(0, 32'h0000_0500, 32'h6666_6666);
        tick();
        check("rst_mid_busy", mem_req, 1);
        set_ic(32'h0000_0600);
        tick();
        reset = 1'b1;
        tick();
        check("rst_mid_mem_req", mem_req, 0);
        check("rst_mid_acks", {ic_ack, dc_ack}, 0);
        reset = 1'b0;
        run_txn("rst_then_i", 0, 0, 32'h0000_0600, 0, 0, 32'h1357_9BDF, 32'h1357_9BDF, 0, 1);
        run_txn("rst_then_d", 1, 0, 32'h0000_0500, 32'h6666_6666, 0, 32'h2468_ACE0, 32'h2468_ACE0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
